// File: rtl/vend_pkg.sv
// Shared encodings for the vending credit sequencer and its add/sub unit.
package vend_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ZERO = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        CMP,
        VEND,
        CHANGE
    } state_t;

endpackage

// File: rtl/credit_addsub.sv
// Combinational 4-bit add/sub unit; result[4] is carry on ADD, borrow on SUB.
module credit_addsub
    import vend_pkg::*;
(
    input  logic [CREDIT_W-1:0] a,
    input  logic [CREDIT_W-1:0] b,
    input  logic [1:0]          op,
    output logic [CREDIT_W:0]   result
);

    // Select the operation; unknown ops produce zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vend_credit_seq.sv
// Credit sequencer: accepts coins/selections, drives the shared add/sub unit
// one operation per cycle, and pays change out one unit per cycle.
module vend_credit_seq
    import vend_pkg::*;
#(
    parameter int CREDIT_MAX  = 15,
    parameter int CHANGE_UNIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    output logic       coin_ready,
    input  logic       sel_valid,
    input  logic [3:0] sel_price,
    output logic       sel_ready,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic       vend_pulse,
    output logic       change_pulse,
    output logic       reject_coin,
    output logic       insufficient,
    output logic       busy
);

    localparam logic [CREDIT_W-1:0] CU    = CHANGE_UNIT[CREDIT_W-1:0];
    localparam logic [CREDIT_W:0]   CMAX5 = CREDIT_MAX[CREDIT_W:0];

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] operand_q, operand_d;
    logic [CREDIT_W-1:0] b_mux;
    logic [1:0]          op;
    logic [CREDIT_W:0]   result;

    credit_addsub u_addsub (
        .a      (credit_q),
        .b      (b_mux),
        .op     (op),
        .result (result)
    );

    assign credit = credit_q;
    assign busy   = (state != IDLE);

    // State, credit and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            credit_q  <= '0;
            operand_q <= '0;
        end else begin
            state     <= state_nxt;
            credit_q  <= credit_d;
            operand_q <= operand_d;
        end
    end

    // Next-state, operand mux, datapath op and pulse decode.
    always_comb begin
        state_nxt    = state;
        credit_d     = credit_q;
        operand_d    = operand_q;
        b_mux        = operand_q;
        op           = OP_ZERO;
        coin_ready   = 1'b0;
        sel_ready    = 1'b0;
        vend_pulse   = 1'b0;
        change_pulse = 1'b0;
        reject_coin  = 1'b0;
        insufficient = 1'b0;
        case (state)
            IDLE: begin
                sel_ready  = !cancel;
                coin_ready = !cancel && !sel_valid;
                if (cancel) begin
                    if (credit_q >= CU) state_nxt = CHANGE;
                end else if (sel_valid) begin
                    operand_d = sel_price;
                    state_nxt = CMP;
                end else if (coin_valid) begin
                    operand_d = coin_value;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                op = OP_ADD;
                if (result > CMAX5) reject_coin = 1'b1;
                else                credit_d    = result[CREDIT_W-1:0];
                state_nxt = IDLE;
            end
            CMP: begin
                op = OP_SUB;
                if (result[CREDIT_W]) begin
                    insufficient = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    credit_d  = result[CREDIT_W-1:0];
                    state_nxt = VEND;
                end
            end
            VEND: begin
                vend_pulse = 1'b1;
                state_nxt  = (credit_q >= CU) ? CHANGE : IDLE;
            end
            CHANGE: begin
                b_mux = CU;
                op    = OP_SUB;
                if (!result[CREDIT_W]) begin
                    change_pulse = 1'b1;
                    credit_d     = result[CREDIT_W-1:0];
                    if (result[CREDIT_W-1:0] < CU) state_nxt = IDLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vend_credit_seq.sv
// Bench for vend_credit_seq: table-driven transactions with a scoreboard
// queue, plus hand sequences for priority and mid-operation reset.
module tb_vend_credit_seq;

    typedef struct {
        int kind;       // 0 coin, 1 selection, 2 cancel
        int val;
        int e_credit;
        int e_rej;
        int e_ins;
        int e_vend;
        int e_chg;
        int e_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_price = '0;
    logic       cancel = 1'b0;

    logic       a_coin_ready, a_sel_ready, a_vend, a_chg, a_rej, a_ins, a_busy;
    logic [3:0] a_credit;
    logic       b_coin_ready, b_sel_ready, b_vend, b_chg, b_rej, b_ins, b_busy;
    logic [3:0] b_credit;

    logic       which = 1'b0;
    logic       m_coin_ready, m_sel_ready, m_vend, m_chg, m_rej, m_ins, m_busy;
    logic [3:0] m_credit;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    vend_credit_seq #(.CREDIT_MAX(15), .CHANGE_UNIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(a_coin_ready),
        .sel_valid(sel_valid), .sel_price(sel_price), .sel_ready(a_sel_ready),
        .cancel(cancel), .credit(a_credit),
        .vend_pulse(a_vend), .change_pulse(a_chg), .reject_coin(a_rej),
        .insufficient(a_ins), .busy(a_busy)
    );

    vend_credit_seq #(.CREDIT_MAX(15), .CHANGE_UNIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(b_coin_ready),
        .sel_valid(sel_valid), .sel_price(sel_price), .sel_ready(b_sel_ready),
        .cancel(cancel), .credit(b_credit),
        .vend_pulse(b_vend), .change_pulse(b_chg), .reject_coin(b_rej),
        .insufficient(b_ins), .busy(b_busy)
    );

    assign m_coin_ready = which ? b_coin_ready : a_coin_ready;
    assign m_sel_ready  = which ? b_sel_ready  : a_sel_ready;
    assign m_vend       = which ? b_vend       : a_vend;
    assign m_chg        = which ? b_chg        : a_chg;
    assign m_rej        = which ? b_rej        : a_rej;
    assign m_ins        = which ? b_ins        : a_ins;
    assign m_busy       = which ? b_busy       : a_busy;
    assign m_credit     = which ? b_credit     : a_credit;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one transaction, push its expectation, then watch the DUT until
    // it returns to IDLE and compare against the popped expectation.
    task automatic run_vec(input vec_t v, input logic sel2);
        vec_t e;
        int   w, nb, nr, ni, nv, nc, ov, c;
        bit   done;
        which = sel2;
        q.push_back(v);
        @(negedge clk);
        if (v.kind == 2) begin
            cancel = 1'b1;
            @(posedge clk);
            #1 cancel = 1'b0;
        end else begin
            if (v.kind == 0) begin
                coin_valid = 1'b1;
                coin_value = v.val[3:0];
            end else begin
                sel_valid = 1'b1;
                sel_price = v.val[3:0];
            end
            #1;
            w = 0;
            while (!((v.kind == 0) ? m_coin_ready : m_sel_ready) && w < 50) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= 50) check("handshake_timeout", w, 0);
            @(posedge clk);
            #1;
            coin_valid = 1'b0;
            sel_valid  = 1'b0;
        end
        nb = 0; nr = 0; ni = 0; nv = 0; nc = 0; ov = 0; done = 1'b0;
        for (c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!m_busy) begin
                done = 1'b1;
            end else begin
                nb++;
                nr += int'(m_rej);
                ni += int'(m_ins);
                nv += int'(m_vend);
                nc += int'(m_chg);
                if ((int'(m_rej) + int'(m_ins) + int'(m_vend) + int'(m_chg)) > 1) ov++;
            end
        end
        if (!done) check("busy_timeout", c, 0);
        e = q.pop_front();
        check("credit", int'(m_credit), e.e_credit);
        check("reject_coin", nr, e.e_rej);
        check("insufficient", ni, e.e_ins);
        check("vend_pulse", nv, e.e_vend);
        check("change_pulses", nc, e.e_chg);
        check("busy_cycles", nb, e.e_busy);
        check("pulse_overlap", ov, 0);
    endtask

    initial begin
        int chg;
        vecs[0]  = '{0, 5,  5,  0, 0, 0, 0,  1};
        vecs[1]  = '{0, 3,  8,  0, 0, 0, 0,  1};
        vecs[2]  = '{1, 10, 8,  0, 1, 0, 0,  1};
        vecs[3]  = '{1, 5,  0,  0, 0, 1, 3,  5};
        vecs[4]  = '{0, 12, 12, 0, 0, 0, 0,  1};
        vecs[5]  = '{0, 5,  12, 1, 0, 0, 0,  1};
        vecs[6]  = '{0, 3,  15, 0, 0, 0, 0,  1};
        vecs[7]  = '{1, 0,  0,  0, 0, 1, 15, 17};
        vecs[8]  = '{2, 0,  0,  0, 0, 0, 0,  0};
        vecs[9]  = '{0, 15, 15, 0, 0, 0, 0,  1};
        vecs[10] = '{0, 1,  15, 1, 0, 0, 0,  1};
        vecs[11] = '{2, 0,  0,  0, 0, 0, 15, 15};
        vecs[12] = '{1, 1,  0,  0, 1, 0, 0,  1};

        // Reset state.
        #2;
        check("rst_credit", int'(a_credit), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_pulses", int'(a_vend) + int'(a_chg) + int'(a_rej) + int'(a_ins), 0);
        check("rst_sel_ready", int'(a_sel_ready), 1);
        check("rst_coin_ready", int'(a_coin_ready), 1);
        do_reset();

        for (int i = 0; i < 13; i++) run_vec(vecs[i], 1'b0);

        // Simultaneous cancel, selection and coin at credit 4.
        do_reset();
        run_vec('{0, 4, 4, 0, 0, 0, 0, 1}, 1'b0);
        @(negedge clk);
        cancel = 1'b1; sel_valid = 1'b1; sel_price = 4'd2;
        coin_valid = 1'b1; coin_value = 4'd1;
        #1;
        check("prio_sel_ready", int'(a_sel_ready), 0);
        check("prio_coin_ready", int'(a_coin_ready), 0);
        @(posedge clk);
        #1 cancel = 1'b0;
        chg = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!a_busy) break;
            if (c == 0) check("busy_readies", int'(a_sel_ready) + int'(a_coin_ready), 0);
            chg += int'(a_chg);
        end
        check("prio_change", chg, 4);
        check("prio_credit", int'(a_credit), 0);
        check("prio_sel_first", int'(a_sel_ready), 1);
        check("prio_coin_held", int'(a_coin_ready), 0);
        @(posedge clk);
        #1 sel_valid = 1'b0;
        @(negedge clk);
        check("prio_insufficient", int'(a_ins), 1);
        @(negedge clk);
        check("prio_coin_ready", int'(a_coin_ready), 1);
        @(posedge clk);
        #1 coin_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("prio_coin_credit", int'(a_credit), 1);

        // Reset asserted mid-CHANGE at credit 6.
        do_reset();
        run_vec('{0, 6, 6, 0, 0, 0, 0, 1}, 1'b0);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("midrst_pre_chg", int'(a_chg), 1);
        check("midrst_pre_credit", int'(a_credit), 6);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_credit", int'(a_credit), 0);
        check("midrst_chg", int'(a_chg), 0);
        check("midrst_busy", int'(a_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chg = 0;
        repeat (10) begin
            @(negedge clk);
            chg += int'(a_chg);
        end
        check("midrst_no_pulses", chg, 0);
        check("midrst_credit_after", int'(a_credit), 0);

        // CHANGE_UNIT = 2: cancel at credit 7 leaves residual 1.
        do_reset();
        run_vec('{0, 7, 7, 0, 0, 0, 0, 1}, 1'b1);
        run_vec('{2, 0, 1, 0, 0, 0, 3, 3}, 1'b1);
        run_vec('{1, 0, 1, 0, 0, 1, 0, 2}, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_credit_seq.md
Name: vend_credit_seq

Overview:
- Sequencing controller for the vending machine's shared 4-bit add/sub credit datapath.
- Accepts coin and selection requests over valid/ready handshakes and tracks the customer's credit.
- Drives the add/sub unit one operation per cycle to add coins, check and deduct price, and pay change out one unit per cycle.
- Sits between the coin/keypad front end and the dispense/change actuators.

Parameters:
- CREDIT_MAX, 15: maximum credit held, range 1..15; a coin pushing credit above this is rejected.
- CHANGE_UNIT, 1: value of one change coin, range 1..15; subtracted once per change_pulse.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- coin_valid  in  1  coin event present.
- coin_value  in  4  coin value, unsigned.
- coin_ready  out  1  coin accepted this cycle when high together with coin_valid.
- sel_valid  in  1  product selection present.
- sel_price  in  4  selected product price, unsigned.
- sel_ready  out  1  selection accepted this cycle when high together with sel_valid.
- cancel  in  1  return all credit; level-sampled.
- credit  out  4  current credit, registered.
- vend_pulse  out  1  one-cycle dispense command.
- change_pulse  out  1  one-cycle "eject one CHANGE_UNIT coin".
- reject_coin  out  1  one-cycle pulse: coin refused, credit would exceed CREDIT_MAX.
- insufficient  out  1  one-cycle pulse: price exceeds credit.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; credit=0; operand register=0; vend_pulse, change_pulse, reject_coin, insufficient=0.
  - busy=0.
  - coin_ready and sel_ready follow their IDLE decode below.
  - Reset mid-operation aborts immediately. No pulse completes, and credit is lost to 0.
- Add/sub unit: 4-bit operands a=credit, b=operand, 2-bit op, 5-bit result.
  - op ADD gives a+b.
  - op SUB gives a-b, computed 5 bits wide. result[4]=1 means borrow (a<b).
  - Any other op gives 0.
  - Controller drives op=ZERO in IDLE.
- States: IDLE, ADD, CMP, VEND, CHANGE.
- IDLE, with priority cancel > selection > coin:
  - sel_ready = IDLE & !cancel.
  - coin_ready = IDLE & !cancel & !sel_valid.
  - cancel=1 with credit>=CHANGE_UNIT: go CHANGE. Otherwise cancel has no effect and the state stays IDLE.
  - Selection handshake: latch sel_price into operand, go CMP.
  - Coin handshake: latch coin_value into operand, go ADD.
  - Requests that are not accepted stay pending. The front end holds valid high.
- ADD (1 cycle), op=ADD:
  - If result > CREDIT_MAX: reject_coin=1 and credit unchanged.
  - Else credit<=result[3:0].
  - Next state IDLE.
  - Timing: coin accepted in cycle N, credit visible in N+2, reject_coin high in N+1.
- CMP (1 cycle), op=SUB:
  - If result[4]=1: insufficient=1, credit unchanged, next state IDLE.
  - Else credit<=result[3:0], next state VEND.
  - A price of 0 vends with credit unchanged.
- VEND (1 cycle): vend_pulse=1.
  - Next state CHANGE if the new credit >= CHANGE_UNIT, else IDLE.
- CHANGE, operand forced to CHANGE_UNIT, op=SUB:
  - Each cycle with credit >= CHANGE_UNIT: change_pulse=1 and credit<=credit-CHANGE_UNIT.
  - When the remaining credit < CHANGE_UNIT, go IDLE.
  - A residual below CHANGE_UNIT is retained in credit.
  - Entering CHANGE with credit C gives floor(C/CHANGE_UNIT) consecutive pulses.
- Timing rules:
  - cancel, coin_valid and sel_valid are ignored outside IDLE. Both readies are 0 there.
  - All pulse outputs are registered-decode and last exactly one cycle.
  - Pulses are mutually exclusive per cycle.
- Widths: credit never wraps. Overflow is caught by the ADD check and underflow by the CMP borrow.

Decomposition:
- Shared package vend_pkg:
  - op encodings: OP_ADD=2'b00, OP_SUB=2'b01, OP_ZERO=2'b10.
  - state enum: IDLE, ADD, CMP, VEND, CHANGE.
  - width constant CREDIT_W=4.
- One sub-module, credit_addsub: the combinational add/sub unit above, instantiated once.
- FSM, operand mux and credit register live in vend_credit_seq.

Test Plan:
- Reset, then coin 5 followed by coin 3 → credit=5 two cycles after the first accept, then credit=8; no reject; busy high exactly one cycle per coin.
- Credit 12, coin 5, CREDIT_MAX=15 → reject_coin one cycle, credit stays 12; then coin 3 → credit 15, no reject.
- Credit 8, select price 10 → insufficient one cycle, no vend_pulse, credit 8, back in IDLE.
- Credit 8, select price 5, CHANGE_UNIT=1 → vend_pulse one cycle, then 3 consecutive change_pulse, credit 0, busy falls. With CHANGE_UNIT=2 and credit 7, a cancel gives 3 pulses and residual credit 1.
- Credit 4 with cancel, sel_valid and coin_valid all high in the same IDLE cycle → sel_ready=0, coin_ready=0, 4 change_pulses. The coin and selection are accepted only after return to IDLE with cancel low, selection first.
- rst_n dropped mid-CHANGE at credit 6 → credit, change_pulse and busy go to 0 asynchronously in the same cycle; no further pulses after release.
